// File: rtl/tx_seq_ctrl_pkg.sv
// Shared definitions for the transmit sequencer and the receive-side
// delay controller: state encoding, line count, LUT stride and widths.
package tx_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FIRE   = 2'd2,
    ST_LISTEN = 2'd3
  } tx_state_e;

  localparam int TX_NUM_LINES  = 61;
  localparam int TX_N_ELEM     = 64;
  localparam int TX_WIDTH_DEF  = 8;
  localparam int TX_PRI_CYCLES = 20000;
  localparam int TX_CNT_WD     = 20;
  localparam int TX_ADDR_WD    = 12;
  localparam int TX_LINE_SHIFT = 6;
  localparam int TX_LINE_WD    = 8;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int idx_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/tx_period_timer.sv
// Line period timer: counts cycles from LOAD entry and flags the last
// cycle of the line (and the cycle before it, so registered outputs can
// land on the last cycle).
// Optional macro TX_PRI_OVERRIDE_EN: period comes from pri_cfg_i, sampled
// on each LOAD entry and clamped to at least N_ELEM+TX_WIDTH+1.
module tx_period_timer
  import tx_seq_ctrl_pkg::*;
#(
  parameter int N_ELEM     = TX_N_ELEM,
  parameter int TX_WIDTH   = TX_WIDTH_DEF,
  parameter int PRI_CYCLES = TX_PRI_CYCLES,
  parameter int CNT_WD     = TX_CNT_WD
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef TX_PRI_OVERRIDE_EN
  input  logic [CNT_WD-1:0] pri_cfg_i,
`endif
  input  logic              start_i,
  input  logic              run_i,
  output logic [CNT_WD-1:0] period_cnt_o,
  output logic              tc_o,
  output logic              tc_pre_o
);

  localparam logic [CNT_WD-1:0] PRI_FLOOR = CNT_WD'(N_ELEM + TX_WIDTH);

  logic [CNT_WD-1:0] cnt_q, cnt_d;
  logic [CNT_WD-1:0] pri_s;

`ifdef TX_PRI_OVERRIDE_EN
  logic [CNT_WD-1:0] pri_q, pri_d, pri_clamp_s;

  // Clamp the requested period and latch it for the line about to start.
  always_comb begin
    pri_clamp_s = pri_cfg_i;
    if (pri_cfg_i <= PRI_FLOOR) begin
      pri_clamp_s = PRI_FLOOR + CNT_WD'(1);
    end else begin
      pri_clamp_s = pri_cfg_i;
    end
    if (start_i) begin
      pri_d = pri_clamp_s;
    end else begin
      pri_d = pri_q;
    end
  end

  // Period register for the active line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= CNT_WD'(PRI_CYCLES);
    end else begin
      pri_q <= pri_d;
    end
  end

  assign pri_s = pri_q;
`else
  assign pri_s = CNT_WD'(PRI_CYCLES);
`endif

  // Clear on LOAD entry, count while a line is running, rest at zero in IDLE.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CNT_WD'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // Period counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign period_cnt_o = cnt_q;
  assign tc_o         = (cnt_q == (pri_s - CNT_WD'(1)));
  assign tc_pre_o     = (cnt_q == (pri_s - CNT_WD'(2)));

endmodule

// File: rtl/tx_seq_ctrl.sv
// Transmit scan-line sequencer: per line, preload pulser delays from the
// TX LUT, fire tx_en, then listen until the line period expires.
// Optional macro TX_PRI_OVERRIDE_EN adds the pri_cfg period override port.
module tx_seq_ctrl
  import tx_seq_ctrl_pkg::*;
#(
  parameter int NUM_LINES  = TX_NUM_LINES,
  parameter int N_ELEM     = TX_N_ELEM,
  parameter int TX_WIDTH   = TX_WIDTH_DEF,
  parameter int PRI_CYCLES = TX_PRI_CYCLES,
  parameter int CNT_WD     = TX_CNT_WD,
  parameter int ADDR_WD    = TX_ADDR_WD,
  parameter int LINE_SHIFT = TX_LINE_SHIFT
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef TX_PRI_OVERRIDE_EN
  input  logic [CNT_WD-1:0]  pri_cfg,
`endif
  input  logic               enable,
  output logic               tx_en,
  output logic               tx_lut_rd,
  output logic [ADDR_WD-1:0] tx_lut_addr,
  output logic [7:0]         tx_line,
  output logic               frame_start,
  output logic               frame_end,
  output logic               busy
);

  localparam int IDX_WD  = idx_width(N_ELEM);
  localparam int FIRE_WD = idx_width(TX_WIDTH);
  localparam logic [IDX_WD-1:0]     LAST_IDX  = IDX_WD'(N_ELEM - 1);
  localparam logic [FIRE_WD-1:0]    LAST_FIRE = FIRE_WD'(TX_WIDTH - 1);
  localparam logic [TX_LINE_WD-1:0] LINE_ONE  = TX_LINE_WD'(1);
  localparam logic [TX_LINE_WD-1:0] LINE_LAST = TX_LINE_WD'(NUM_LINES);

  // Configuration sanity, caught at elaboration.
  if (NUM_LINES * (2 ** LINE_SHIFT) > (2 ** ADDR_WD)) begin : g_bad_addr
    $error("tx_seq_ctrl: NUM_LINES << LINE_SHIFT exceeds the LUT address space");
  end
  if (PRI_CYCLES <= N_ELEM + TX_WIDTH) begin : g_bad_pri
    $error("tx_seq_ctrl: PRI_CYCLES must exceed N_ELEM + TX_WIDTH");
  end
  if (TX_WIDTH < 1) begin : g_bad_width
    $error("tx_seq_ctrl: TX_WIDTH must be at least 1");
  end

  tx_state_e               state_q, state_d;
  logic [IDX_WD-1:0]       elem_idx_q, elem_idx_d;
  logic [FIRE_WD-1:0]      fire_cnt_q, fire_cnt_d;
  logic [TX_LINE_WD-1:0]   line_q, line_d;
  logic                    tx_en_q, tx_en_d;
  logic                    rd_q, rd_d;
  logic [ADDR_WD-1:0]      addr_q, addr_d;
  logic                    fs_q, fs_d;
  logic                    fe_q, fe_d;
  logic                    busy_q, busy_d;

  logic                    load_entry_s;
  logic                    run_s;
  logic                    tc_s;
  logic                    tc_pre_s;
  logic [CNT_WD-1:0]       period_cnt_s;
  logic [ADDR_WD-1:0]      line_base_s;

  tx_period_timer #(
    .N_ELEM    (N_ELEM),
    .TX_WIDTH  (TX_WIDTH),
    .PRI_CYCLES(PRI_CYCLES),
    .CNT_WD    (CNT_WD)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef TX_PRI_OVERRIDE_EN
    .pri_cfg_i   (pri_cfg),
`endif
    .start_i     (load_entry_s),
    .run_i       (run_s),
    .period_cnt_o(period_cnt_s),
    .tc_o        (tc_s),
    .tc_pre_o    (tc_pre_s)
  );

  // Next-state logic: line sequencing, element and pulse-width counting.
  always_comb begin
    state_d    = state_q;
    elem_idx_d = elem_idx_q;
    fire_cnt_d = fire_cnt_q;
    line_d     = line_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_LOAD;
          line_d     = LINE_ONE;
          elem_idx_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (elem_idx_q == LAST_IDX) begin
          state_d    = ST_FIRE;
          elem_idx_d = '0;
          fire_cnt_d = '0;
        end else begin
          elem_idx_d = elem_idx_q + IDX_WD'(1);
        end
      end
      ST_FIRE: begin
        if (fire_cnt_q == LAST_FIRE) begin
          state_d    = ST_LISTEN;
          fire_cnt_d = '0;
        end else begin
          fire_cnt_d = fire_cnt_q + FIRE_WD'(1);
        end
      end
      ST_LISTEN: begin
        if (tc_s) begin
          elem_idx_d = '0;
          if (line_q < LINE_LAST) begin
            state_d = ST_LOAD;
            line_d  = line_q + LINE_ONE;
          end else if (enable) begin
            state_d = ST_LOAD;
            line_d  = LINE_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_LISTEN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output comes from a flop.
  always_comb begin
    load_entry_s = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    run_s        = (state_d != ST_IDLE);
    tx_en_d      = (state_d == ST_FIRE);
    rd_d         = (state_d == ST_LOAD);
    busy_d       = (state_d != ST_IDLE);
    line_base_s  = ADDR_WD'(line_d - LINE_ONE) << LINE_SHIFT;
    addr_d       = addr_q;
    if (rd_d) begin
      addr_d = line_base_s + ADDR_WD'(elem_idx_d);
    end else begin
      addr_d = addr_q;
    end
    fs_d = (state_d == ST_FIRE) && (state_q == ST_LOAD) && (line_d == LINE_ONE);
    fe_d = (state_d == ST_LISTEN) && tc_pre_s && (line_q == LINE_LAST);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      elem_idx_q <= '0;
      fire_cnt_q <= '0;
      line_q     <= '0;
      tx_en_q    <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      fs_q       <= 1'b0;
      fe_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      elem_idx_q <= elem_idx_d;
      fire_cnt_q <= fire_cnt_d;
      line_q     <= line_d;
      tx_en_q    <= tx_en_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      fs_q       <= fs_d;
      fe_q       <= fe_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_en       = tx_en_q;
  assign tx_lut_rd   = rd_q;
  assign tx_lut_addr = addr_q;
  assign tx_line     = line_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign busy        = busy_q;

  logic unused_s;
  assign unused_s = ^period_cnt_s;

endmodule

// File: tb/tb_tx_seq_ctrl.sv
// Scoreboard bench for tx_seq_ctrl: expected LUT reads, tx_en edges and
// frame pulses are queued with their cycle numbers when enable is driven,
// then popped and compared as the DUT produces them.
module tb_tx_seq_ctrl;

  localparam int NUM_LINES  = 3;
  localparam int N_ELEM     = 4;
  localparam int TX_WIDTH   = 2;
  localparam int PRI        = 16;
  localparam int LINE_SHIFT = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        tx_en;
  logic        tx_lut_rd;
  logic [11:0] tx_lut_addr;
  logic [7:0]  tx_line;
  logic        frame_start;
  logic        frame_end;
  logic        busy;
`ifdef TX_PRI_OVERRIDE_EN
  logic [19:0] pri_cfg = 20'd16;
`endif

  typedef struct {
    int c;
    int v;
  } ev_t;

  ev_t rd_q[$];
  ev_t rise_q[$];
  int  fall_q[$];
  int  fs_q[$];
  int  fe_q[$];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_rise = 0;
  logic tx_en_prev = 1'b0;
  ev_t  mon_ev;
  int   mon_c;

  tx_seq_ctrl #(
    .NUM_LINES (NUM_LINES),
    .N_ELEM    (N_ELEM),
    .TX_WIDTH  (TX_WIDTH),
    .PRI_CYCLES(PRI),
    .CNT_WD    (20),
    .ADDR_WD   (12),
    .LINE_SHIFT(LINE_SHIFT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef TX_PRI_OVERRIDE_EN
    .pri_cfg    (pri_cfg),
`endif
    .enable     (enable),
    .tx_en      (tx_en),
    .tx_lut_rd  (tx_lut_rd),
    .tx_lut_addr(tx_lut_addr),
    .tx_line    (tx_line),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Cycle counter: value seen at a negedge is the number of posedges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_line(input int base, input int line, input int pri);
    for (int e = 0; e < N_ELEM; e++) begin
      rd_q.push_back('{base + e, ((line - 1) << LINE_SHIFT) + e});
    end
    rise_q.push_back('{base + N_ELEM, line});
    fall_q.push_back(base + N_ELEM + TX_WIDTH);
    if (line == 1) fs_q.push_back(base + N_ELEM);
    if (line == NUM_LINES) fe_q.push_back(base + pri - 1);
  endtask

  task automatic push_frames(input int t0, input int nlines, input int pri);
    for (int i = 0; i < nlines; i++) begin
      push_line(t0 + i * pri, (i % NUM_LINES) + 1, pri);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge clk) begin
    if (tx_lut_rd) begin
      if (rd_q.size() == 0) begin
        check_eq("rd_unexpected", 1, 0);
      end else begin
        mon_ev = rd_q.pop_front();
        check_eq("rd_cycle", cyc, mon_ev.c);
        check_eq("rd_addr", int'(tx_lut_addr), mon_ev.v);
      end
    end
    if (tx_en && !tx_en_prev) begin
      n_rise <= n_rise + 1;
      if (rise_q.size() == 0) begin
        check_eq("rise_unexpected", 1, 0);
      end else begin
        mon_ev = rise_q.pop_front();
        check_eq("rise_cycle", cyc, mon_ev.c);
        check_eq("rise_line", int'(tx_line), mon_ev.v);
      end
    end
    if (!tx_en && tx_en_prev) begin
      if (fall_q.size() == 0) begin
        check_eq("fall_unexpected", 1, 0);
      end else begin
        mon_c = fall_q.pop_front();
        check_eq("fall_cycle", cyc, mon_c);
      end
    end
    if (frame_start) begin
      if (fs_q.size() == 0) begin
        check_eq("fs_unexpected", 1, 0);
      end else begin
        mon_c = fs_q.pop_front();
        check_eq("fs_cycle", cyc, mon_c);
      end
    end
    if (frame_end) begin
      if (fe_q.size() == 0) begin
        check_eq("fe_unexpected", 1, 0);
      end else begin
        mon_c = fe_q.pop_front();
        check_eq("fe_cycle", cyc, mon_c);
      end
    end
    tx_en_prev <= tx_en;
  end

  initial begin
    int t0;
    int r0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_tx_en", int'(tx_en), 0);
    check_eq("rst_rd", int'(tx_lut_rd), 0);
    check_eq("rst_addr", int'(tx_lut_addr), 0);
    check_eq("rst_line", int'(tx_line), 0);
    check_eq("rst_fs", int'(frame_start), 0);
    check_eq("rst_fe", int'(frame_end), 0);
    check_eq("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", int'(busy), 0);

    // Single frame from a one-cycle enable pulse.
    t0 = cyc + 1;
    enable = 1'b1;
    push_frames(t0, 3, PRI);
    @(negedge clk);
    enable = 1'b0;
    wait_until(t0 + 47);
    check_eq("s1_busy_last", int'(busy), 1);
    wait_until(t0 + 48);
    check_eq("s1_busy_idle", int'(busy), 0);
    check_eq("s1_line_hold", int'(tx_line), NUM_LINES);
    repeat (4) @(negedge clk);

    // Continuous frames with enable held across the frame boundary.
    t0 = cyc + 1;
    enable = 1'b1;
    push_frames(t0, 6, PRI);
    wait_until(t0 + 48);
    check_eq("s2_line_wrap", int'(tx_line), 1);
    wait_until(t0 + 50);
    enable = 1'b0;
    wait_until(t0 + 96);
    check_eq("s2_busy_idle", int'(busy), 0);
    repeat (4) @(negedge clk);

    // Enable dropped in line 1, re-raised and dropped again in line 2.
    #1 r0 = n_rise;
    @(negedge clk);
    t0 = cyc + 1;
    enable = 1'b1;
    push_frames(t0, 3, PRI);
    wait_until(t0 + 10);
    enable = 1'b0;
    wait_until(t0 + 20);
    enable = 1'b1;
    wait_until(t0 + 25);
    enable = 1'b0;
    wait_until(t0 + 48);
    check_eq("s3_busy_idle", int'(busy), 0);
    repeat (6) @(negedge clk);
    #1 check_eq("s3_rise_count", n_rise - r0, 3);
    @(negedge clk);

    // Reset asserted in the middle of FIRE, then restart.
    t0 = cyc + 1;
    enable = 1'b1;
    for (int e = 0; e < N_ELEM; e++) rd_q.push_back('{t0 + e, e});
    rise_q.push_back('{t0 + N_ELEM, 1});
    fs_q.push_back(t0 + N_ELEM);
    fall_q.push_back(t0 + N_ELEM + 1);
    wait_until(t0 + N_ELEM);
    #2 rst_n = 1'b0;
    #1;
    check_eq("s4_async_tx_en", int'(tx_en), 0);
    check_eq("s4_async_busy", int'(busy), 0);
    check_eq("s4_async_line", int'(tx_line), 0);
    repeat (3) @(negedge clk);
    t0 = cyc + 1;
    rst_n = 1'b1;
    push_frames(t0, 3, PRI);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_until(t0 + 48);
    check_eq("s4_busy_idle", int'(busy), 0);
    repeat (4) @(negedge clk);

`ifdef TX_PRI_OVERRIDE_EN
    // Period override: 24 cycles, then a short request clamped to 7.
    pri_cfg = 20'd24;
    t0 = cyc + 1;
    enable = 1'b1;
    push_frames(t0, 3, 24);
    @(negedge clk);
    enable = 1'b0;
    wait_until(t0 + 72);
    check_eq("s5_busy_idle_24", int'(busy), 0);
    repeat (3) @(negedge clk);
    pri_cfg = 20'd3;
    t0 = cyc + 1;
    enable = 1'b1;
    push_frames(t0, 3, 7);
    @(negedge clk);
    enable = 1'b0;
    wait_until(t0 + 20);
    check_eq("s5_busy_last_7", int'(busy), 1);
    wait_until(t0 + 21);
    check_eq("s5_busy_idle_7", int'(busy), 0);
    repeat (4) @(negedge clk);
`endif

    // Every queued expectation must have been consumed.
    check_eq("left_rd", rd_q.size(), 0);
    check_eq("left_rise", rise_q.size(), 0);
    check_eq("left_fall", fall_q.size(), 0);
    check_eq("left_fs", fs_q.size(), 0);
    check_eq("left_fe", fe_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
